// File: rtl/ret_addr_stack.sv
// Return-address stack and PC-source selector feeding the RAT CPU program counter.
// Chooses the PC load value each cycle and keeps a LIFO of return addresses.
module ret_addr_stack #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [9:0]  INTR_VEC = 10'h3FF
) (
    input  logic                         RS_CLK,
    input  logic                         RS_RST_N,
    input  logic [9:0]                   RS_PC,
    input  logic [9:0]                   RS_IMM,
    input  logic                         RS_BRANCH,
    input  logic                         RS_CALL,
    input  logic                         RS_RET,
    input  logic                         RS_INTR,
    input  logic                         RS_ERR_CLR,
    output logic [9:0]                   RS_DIN,
    output logic                         RS_LD,
    output logic                         RS_EMPTY,
    output logic                         RS_FULL,
    output logic [$clog2(DEPTH+1)-1:0]   RS_CNT,
    output logic                         RS_OVF,
    output logic                         RS_UNF
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [9:0]    entry [DEPTH];
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          unf;
    logic          push;
    logic          pop;
    logic [9:0]    push_val;
    logic          empty;
    logic          full;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] wr_idx;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign top_idx = AW'(cnt - 1'b1);
    assign wr_idx  = AW'(cnt);

    // Requests are masked during reset so nothing reaches the PC or the stack.
    always_comb begin
        push     = 1'b0;
        pop      = 1'b0;
        push_val = '0;
        RS_DIN   = '0;
        RS_LD    = 1'b0;
        if (RS_RST_N) begin
            if (RS_INTR) begin
                push     = 1'b1;
                push_val = RS_PC;
                RS_DIN   = INTR_VEC;
                RS_LD    = 1'b1;
            end else if (RS_RET) begin
                pop    = 1'b1;
                RS_DIN = empty ? '0 : entry[top_idx];
                RS_LD  = 1'b1;
            end else if (RS_CALL) begin
                push     = 1'b1;
                push_val = RS_PC + 10'd1;
                RS_DIN   = RS_IMM;
                RS_LD    = 1'b1;
            end else if (RS_BRANCH) begin
                RS_DIN = RS_IMM;
                RS_LD  = 1'b1;
            end
        end
    end

    always_ff @(posedge RS_CLK or negedge RS_RST_N) begin
        if (!RS_RST_N) begin
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (push && !full) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !empty) begin
                cnt <= cnt - 1'b1;
            end
            // A new error in the same cycle as a clear keeps the flag set.
            ovf <= (ovf && !RS_ERR_CLR) || (push && full);
            unf <= (unf && !RS_ERR_CLR) || (pop && empty);
        end
    end

    // Entry storage is intentionally not reset.
    always_ff @(posedge RS_CLK) begin
        if (push && !full) begin
            entry[wr_idx] <= push_val;
        end
    end

    assign RS_EMPTY = empty;
    assign RS_FULL  = full;
    assign RS_CNT   = cnt;
    assign RS_OVF   = ovf;
    assign RS_UNF   = unf;

endmodule

// File: tb/tb_ret_addr_stack.sv
// Directed self-checking bench for ret_addr_stack (DEPTH = 8).
module tb_ret_addr_stack;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] pc, imm;
    logic       branch, call, ret, intr, err_clr;
    logic [9:0] din;
    logic       ld, empty, full, ovf, unf;
    logic [3:0] cnt;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    ret_addr_stack #(.DEPTH(8), .INTR_VEC(10'h3FF)) dut (
        .RS_CLK(clk), .RS_RST_N(rst_n), .RS_PC(pc), .RS_IMM(imm),
        .RS_BRANCH(branch), .RS_CALL(call), .RS_RET(ret), .RS_INTR(intr),
        .RS_ERR_CLR(err_clr), .RS_DIN(din), .RS_LD(ld), .RS_EMPTY(empty),
        .RS_FULL(full), .RS_CNT(cnt), .RS_OVF(ovf), .RS_UNF(unf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        branch = 1'b0; call = 1'b0; ret = 1'b0; intr = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; pc = '0; imm = '0;
        idle();
        call = 1'b1;
        #1;
        check_eq("rst_cnt",   10'(cnt),   10'd0);
        check_eq("rst_empty", 10'(empty), 10'd1);
        check_eq("rst_full",  10'(full),  10'd0);
        check_eq("rst_ovf",   10'(ovf),   10'd0);
        check_eq("rst_unf",   10'(unf),   10'd0);
        check_eq("rst_ld",    10'(ld),    10'd0);
        check_eq("rst_din",   din,        10'h000);
        #6 rst_n = 1'b1;
        idle();
        tick();
        check_eq("idle_ld",  10'(ld), 10'd0);
        check_eq("idle_din", din,     10'h000);

        // CALL then RET
        pc = 10'h010; imm = 10'h080; call = 1'b1;
        #1;
        check_eq("call_din", din,     10'h080);
        check_eq("call_ld",  10'(ld), 10'd1);
        tick(); idle();
        check_eq("call_cnt",   10'(cnt),   10'd1);
        check_eq("call_empty", 10'(empty), 10'd0);
        ret = 1'b1;
        #1;
        check_eq("ret_din", din,     10'h011);
        check_eq("ret_ld",  10'(ld), 10'd1);
        tick(); idle();
        check_eq("ret_cnt", 10'(cnt), 10'd0);

        // INTR beats RET
        pc = 10'h055; intr = 1'b1; ret = 1'b1;
        #1;
        check_eq("intr_din", din, 10'h3FF);
        tick(); idle();
        check_eq("intr_cnt", 10'(cnt), 10'd1);
        ret = 1'b1;
        #1;
        check_eq("intr_ret_din", din, 10'h055);
        tick(); idle();

        // Fill to DEPTH, overflow, then drain
        for (int i = 0; i < 9; i++) begin
            pc = 10'(i); imm = 10'(10'h100 + i); call = 1'b1;
            #1;
            check_eq("fill_din", din, 10'(10'h100 + i));
            tick();
            if (i == 7) begin
                check_eq("fill_full", 10'(full), 10'd1);
                check_eq("fill_ovf0", 10'(ovf),  10'd0);
            end
        end
        idle();
        check_eq("ovf_cnt", 10'(cnt), 10'd8);
        check_eq("ovf_set", 10'(ovf), 10'd1);
        for (int k = 0; k < 8; k++) begin
            ret = 1'b1;
            #1;
            check_eq("drain_din", din, 10'(8 - k));
            tick();
        end
        idle();
        check_eq("drain_empty", 10'(empty), 10'd1);
        check_eq("drain_ovf",   10'(ovf),   10'd1);
        err_clr = 1'b1;
        tick(); idle();
        check_eq("ovf_clr", 10'(ovf), 10'd0);

        // Underflow and clear interplay
        ret = 1'b1;
        #1;
        check_eq("unf_din", din,     10'h000);
        check_eq("unf_ld",  10'(ld), 10'd1);
        tick();
        check_eq("unf_set", 10'(unf), 10'd1);
        check_eq("unf_cnt", 10'(cnt), 10'd0);
        err_clr = 1'b1;
        tick(); idle();
        check_eq("unf_set_wins", 10'(unf), 10'd1);
        err_clr = 1'b1;
        tick(); idle();
        check_eq("unf_clr", 10'(unf), 10'd0);

        // PC wrap on CALL, BRANCH leaves stack alone, CALL beats BRANCH
        pc = 10'h3FF; imm = 10'h200; call = 1'b1;
        tick(); idle();
        imm = 10'h123; branch = 1'b1;
        #1;
        check_eq("br_din", din, 10'h123);
        tick(); idle();
        check_eq("br_cnt", 10'(cnt), 10'd1);
        pc = 10'h020; imm = 10'h0AA; call = 1'b1; branch = 1'b1;
        #1;
        check_eq("callbr_din", din, 10'h0AA);
        tick(); idle();
        check_eq("callbr_cnt", 10'(cnt), 10'd2);
        ret = 1'b1; call = 1'b1;
        #1;
        check_eq("retcall_din", din, 10'h021);
        tick(); idle();
        ret = 1'b1;
        #1;
        check_eq("wrap_din", din, 10'h000);
        check_eq("wrap_cnt", 10'(cnt), 10'd1);
        tick(); idle();

        // Asynchronous reset mid-cycle
        for (int i = 0; i < 3; i++) begin
            pc = 10'(10'h030 + i); call = 1'b1;
            tick();
        end
        check_eq("pre_rst_cnt", 10'(cnt), 10'd3);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_cnt",   10'(cnt),   10'd0);
        check_eq("arst_empty", 10'(empty), 10'd1);
        check_eq("arst_ld",    10'(ld),    10'd0);
        check_eq("arst_din",   din,        10'h000);
        #3 rst_n = 1'b1;
        tick(); idle();
        check_eq("post_rst_cnt", 10'(cnt), 10'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
